state_stream_decoder: RTL

- Receiving end of the 2-bit state-code stream produced by the I/S/T toggle FSM (I=2'b01, S=2'b10, T=2'b11).
- The transmitter moves S<->T on in=1 and holds on in=0. This block recovers the in bit stream from that: bit = 1 iff the code changed.
- Recovered bits are packed LSB-first into WIDTH-bit words and delivered over a valid/ready interface.
- Protocol violations are flagged with sticky error codes. The block sits between the FPGA-side FSM output and the word-oriented result path.

---
 rtl/state_stream_decoder.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/state_stream_decoder.sv
// -----------------------------------------------------------------------------
// state_stream_decoder
//
// Receiving end of the 2-bit I/S/T state-code stream (I=01, S=10, T=11).
// The transmitter toggles S<->T for a 1 and holds for a 0, so each recovered
// bit is "did the code change since the previous sample". Recovered bits are
// packed LSB-first into WIDTH-bit words and handed out over valid/ready.
// Protocol violations park the FSM in ERR with a sticky error code.
//
// Optional feature macro: STATE_STREAM_DECODER_FLUSH_EN
//   When defined, adds a flush input (emit a partial word) and an out_len
//   output (number of valid bits in out_data).
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   code_in     in   [1:0] state code from the transmitter
//   code_valid  in   code_in is sampled only when high
//   clr_err     in   synchronous pulse: clear error, counter, partial word,
//                    return to WAIT_I (a pending output word is kept)
//   flush       in   (FLUSH_EN only) emit the partial word in RUN
//   out_len     out  (FLUSH_EN only) valid bit count of out_data
//   out_data    out  [WIDTH-1:0] assembled word
//   out_valid   out  out_data valid, held until accepted
//   out_ready   in   consumer ready
//   err_code    out  00 none, 01 illegal code 00, 10 sequence, 11 overflow
//   bit_count   out  [CNT_W-1:0] recovered bits since reset / clr_err
//   fsm_state   out  [1:0] current FSM state (debug visibility)
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high. Once out_valid rises, out_data holds steady until
// that transfer; a word completing on the transfer edge reloads out_data and
// keeps out_valid high.
// -----------------------------------------------------------------------------
module state_stream_decoder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    localparam int LEN_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       code_in,
    input  logic             code_valid,
    input  logic             clr_err,
`ifdef STATE_STREAM_DECODER_FLUSH_EN
    input  logic             flush,
    output logic [LEN_W-1:0] out_len,
`endif
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] bit_count,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        WAIT_I = 2'd0,
        WAIT_S = 2'd1,
        RUN    = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         prev_q, prev_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic [1:0]         err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;

    logic               flush_req;
    logic               cap;
    logic               bit_val;
    logic               emit;
    logic [WIDTH-1:0]   word;
    logic [LEN_W-1:0]   fill_n;

`ifdef STATE_STREAM_DECODER_FLUSH_EN
    assign flush_req = flush;
    assign out_len   = len_q;
`else
    assign flush_req = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        shift_d = shift_q;
        fill_d  = fill_q;
        data_d  = data_q;
        // A transfer this edge drops valid unless a new word reloads it below.
        valid_d = valid_q && !out_ready;
        err_d   = err_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        cap     = 1'b0;
        bit_val = 1'b0;
        emit    = 1'b0;
        word    = shift_q;
        fill_n  = fill_q;

        if (clr_err) begin
            // clr_err wins over any sample on the same edge.
            state_d = WAIT_I;
            err_d   = 2'b00;
            cnt_d   = '0;
            fill_d  = '0;
            shift_d = '0;
            prev_d  = 2'b00;
        end else begin
            case (state_q)
                WAIT_I: begin
                    if (code_valid) begin
                        if (code_in == 2'b01) begin
                            state_d = WAIT_S;
                        end else if (code_in == 2'b00) begin
                            state_d = ERR;
                            err_d   = 2'b01;
                        end
                    end
                end
                WAIT_S: begin
                    if (code_valid) begin
                        if (code_in == 2'b10) begin
                            state_d = RUN;
                            prev_d  = 2'b10;
                        end else if (code_in == 2'b00) begin
                            state_d = ERR;
                            err_d   = 2'b01;
                        end else if (code_in == 2'b11) begin
                            state_d = ERR;
                            err_d   = 2'b10;
                        end
                    end
                end
                RUN: begin
                    if (code_valid && code_in == 2'b00) begin
                        state_d = ERR;
                        err_d   = 2'b01;
                    end else if (code_valid && code_in == 2'b01) begin
                        state_d = ERR;
                        err_d   = 2'b10;
                    end else begin
                        cap     = code_valid;
                        bit_val = (code_in != prev_q);
                        // Word as it stands including this edge's bit.
                        word    = shift_q | (WIDTH'(cap & bit_val) << fill_q);
                        fill_n  = fill_q + LEN_W'(cap);
                        emit    = (fill_n == LEN_W'(WIDTH)) ||
                                  (flush_req && fill_n != '0);
                        if (emit && valid_q && !out_ready) begin
                            // Nowhere to put the new word: drop it, keep the held one.
                            state_d = ERR;
                            err_d   = 2'b11;
                        end else begin
                            if (cap) begin
                                prev_d = code_in;
                                cnt_d  = cnt_q + CNT_W'(1);
                            end
                            if (emit) begin
                                data_d  = word;
                                valid_d = 1'b1;
                                len_d   = fill_n;
                                shift_d = '0;
                                fill_d  = '0;
                            end else begin
                                shift_d = word;
                                fill_d  = fill_n;
                            end
                        end
                    end
                end
                default: ; // ERR: inputs ignored until clr_err
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_I;
            prev_q  <= 2'b00;
            shift_q <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 2'b00;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            shift_q <= shift_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign err_code  = err_q;
    assign bit_count = cnt_q;
    assign fsm_state = state_q;

endmodule
